snes_controller_emu: RTL and testbench

SNES_CONTROLLER_EMU -- requirements
Module: snes_controller_emu

---
 rtl/snes_controller_emu.sv | 133 +++++++++++++
 tb/tb_snes_controller_emu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/snes_controller_emu.sv
// SNES controller emulator: serialises a 12-button snapshot onto the host's latch/pulse bus.
// Optional SHIFT-frame watchdog is enabled by defining SNES_EMU_WATCHDOG_EN.
module snes_controller_emu #(
    parameter int WDOG_CYCLES = 4095
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        snes_latch,
    input  logic        snes_pulse,
    input  logic [11:0] buttons,
    output logic        snes_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCHED,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        snes_data_d;
    logic        frame_done_d;

    // Stages [1:0] synchronise the host strobes; stage [2] is the edge-detect delay.
    logic [2:0]  latch_pipe;
    logic [2:0]  pulse_pipe;
    logic        latch_s, latch_fall, pulse_rise;

    assign latch_s    = latch_pipe[1];
    assign latch_fall = ~latch_pipe[1] & latch_pipe[2];
    assign pulse_rise = pulse_pipe[1] & ~pulse_pipe[2];

    assign busy = (state_q == ST_LATCHED) || (state_q == ST_SHIFT);

`ifdef SNES_EMU_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_expired;

    assign wdog_expired = (wdog_q == WDOG_LAST);

    // Counts idle cycles inside SHIFT; outside SHIFT it is held clear so entry restarts it.
    always_comb begin
        wdog_d = '0;
        if (state_q == ST_SHIFT && !pulse_rise && !wdog_expired)
            wdog_d = wdog_q + 1'b1;
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset)
            wdog_q <= '0;
        else
            wdog_q <= wdog_d;
    end
`else
    logic wdog_expired;
    logic unused_wdog;

    assign wdog_expired = 1'b0;
    assign unused_wdog  = ^WDOG_CYCLES;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;

        if (latch_s) begin
            state_d   = ST_LATCHED;
            shreg_d   = {4'b0000, buttons};
            bit_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_LATCHED: begin
                    if (latch_fall)
                        state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (pulse_rise) begin
                        shreg_d = {1'b0, shreg_q[15:1]};
                        if (bit_cnt_q == 4'd15) begin
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (wdog_expired) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Output register is fed from next-state values to keep input-to-pin latency at 3 cycles.
        unique case (state_d)
            ST_LATCHED, ST_SHIFT: snes_data_d = ~shreg_d[0];
            ST_DONE:              snes_data_d = 1'b0;
            default:              snes_data_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            latch_pipe <= 3'b000;
            pulse_pipe <= 3'b000;
            state_q    <= ST_IDLE;
            shreg_q    <= 16'h0000;
            bit_cnt_q  <= 4'd0;
            snes_data  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            latch_pipe <= {latch_pipe[1:0], snes_latch};
            pulse_pipe <= {pulse_pipe[1:0], snes_pulse};
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            snes_data  <= snes_data_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_snes_controller_emu.sv
// Randomised self-checking bench for snes_controller_emu against a frame-level reference model.
module tb_snes_controller_emu;

    localparam int WDOG = 100;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        snes_latch;
    logic        snes_pulse;
    logic [11:0] buttons;
    logic        snes_data;
    logic        busy;
    logic        frame_done;

    int errors   = 0;
    int checks   = 0;
    int fd_count = 0;

    snes_controller_emu #(.WDOG_CYCLES(WDOG)) dut (
        .sys_clk    (sys_clk),
        .sys_reset  (sys_reset),
        .snes_latch (snes_latch),
        .snes_pulse (snes_pulse),
        .buttons    (buttons),
        .snes_data  (snes_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Counts cycles with frame_done high; a clean frame adds exactly one.
    always @(posedge sys_clk) begin
        #1;
        if (frame_done === 1'b1)
            fd_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Line level expected after k accepted pulses of a frame captured from b.
    function automatic logic exp_data(input logic [11:0] b, input int k);
        if (k >= 16) return 1'b0;
        if (k >= 12) return 1'b1;
        return ~b[k];
    endfunction

    task automatic do_latch(input logic [11:0] b);
        buttons    = b;
        snes_latch = 1'b1;
        cyc(10);
        snes_latch = 1'b0;
        cyc(6);
    endtask

    task automatic do_pulse();
        snes_pulse = 1'b1;
        cyc(6);
        snes_pulse = 1'b0;
        cyc(6);
    endtask

    task automatic run_pulses(input logic [11:0] b, input int from, input int upto);
        for (int k = from + 1; k <= upto; k++) begin
            do_pulse();
            check($sformatf("data_p%0d", k), 32'(snes_data), 32'(exp_data(b, k)));
            check($sformatf("busy_p%0d", k), 32'(busy), 32'(k < 16));
        end
    endtask

    task automatic full_frame(input logic [11:0] b);
        int fd0;
        fd0 = fd_count;
        do_latch(b);
        check("data_first", 32'(snes_data), 32'(exp_data(b, 0)));
        check("busy_latched", 32'(busy), 32'd1);
        run_pulses(b, 0, 16);
        check("frame_done_once", 32'(fd_count - fd0), 32'd1);
    endtask

    task automatic abort_frame(input logic [11:0] b1, input logic [11:0] b2, input int m);
        int fd0;
        fd0 = fd_count;
        do_latch(b1);
        run_pulses(b1, 0, m);
        do_latch(b2);
        check("abort_first", 32'(snes_data), 32'(exp_data(b2, 0)));
        check("abort_no_fd", 32'(fd_count - fd0), 32'd0);
        run_pulses(b2, 0, 16);
        check("abort_fd_once", 32'(fd_count - fd0), 32'd1);
    endtask

    task automatic reset_frame(input logic [11:0] b, input int m);
        int fd0;
        fd0 = fd_count;
        do_latch(b);
        run_pulses(b, 0, m);
        sys_reset = 1'b1;
        #1;
        check("rst_data", 32'(snes_data), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        cyc(3);
        sys_reset = 1'b0;
        cyc(2);
        for (int k = 0; k < 4; k++) do_pulse();
        check("post_rst_data", 32'(snes_data), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_no_fd", 32'(fd_count - fd0), 32'd0);
    endtask

    task automatic stall_frame(input logic [11:0] b);
        do_latch(b);
        run_pulses(b, 0, 3);
        cyc(110);
`ifdef SNES_EMU_WATCHDOG_EN
        check("wdog_data", 32'(snes_data), 32'd1);
        check("wdog_busy", 32'(busy), 32'd0);
`else
        check("stall_data", 32'(snes_data), 32'(exp_data(b, 3)));
        check("stall_busy", 32'(busy), 32'd1);
`endif
    endtask

    initial begin
        sys_reset  = 1'b1;
        snes_latch = 1'b0;
        snes_pulse = 1'b0;
        buttons    = 12'h000;
        cyc(2);
        check("reset_data", 32'(snes_data), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fd", 32'(frame_done), 32'd0);
        sys_reset = 1'b0;
        cyc(3);
        check("idle_data", 32'(snes_data), 32'd1);

        full_frame(12'h001);
        full_frame(12'hA5A);
        abort_frame(12'(($urandom)), 12'hFFF, 5);
        reset_frame(12'(($urandom)), 8);
        stall_frame(12'(($urandom)));
        full_frame(12'(($urandom)));

        for (int i = 0; i < 10; i++) begin
            logic [11:0] b;
            b = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       abort_frame(b, 12'($urandom), int'($urandom_range(1, 15)));
                1:       reset_frame(b, int'($urandom_range(1, 15)));
                2:       stall_frame(b);
                default: full_frame(b);
            endcase
        end
        full_frame(12'(($urandom)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
